// File: rtl/spi_mem_ctrl_rw_pkg.sv
// Shared definitions for the SPI serial-SRAM controller.
//   SPI_CMD_READ / SPI_CMD_WRITE : 23LC1024-style opcodes
//   NB_W                         : width of the byte-count field
//   CNT_W                        : width of the frame bit counter (up to 8+32+32 bits)
//   state_e                      : controller sequencing states
package spi_mem_ctrl_rw_pkg;
   localparam logic [7:0] SPI_CMD_READ  = 8'h03;
   localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
   localparam int         NB_W          = 3;
   localparam int         CNT_W         = 7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_DONE
   } state_e;
endpackage

// File: rtl/spi_mem_ctrl_rw_if.sv
// Request/response bundle between the core sequencer and the SPI controller.
//   start, is_write, num_bytes, addr, wdata, sign_ext : request (master drives)
//   rdata, busy, done, err                            : response (slave drives)
interface spi_mem_ctrl_rw_if #(
   parameter int ADDR_W    = 24,
   parameter int MAX_BYTES = 4
);
   import spi_mem_ctrl_rw_pkg::*;

   logic                   start;
   logic                   is_write;
   logic [NB_W-1:0]        num_bytes;
   logic [ADDR_W-1:0]      addr;
   logic [8*MAX_BYTES-1:0] wdata;
   logic                   sign_ext;
   logic [31:0]            rdata;
   logic                   busy;
   logic                   done;
   logic                   err;

   modport master (
      output start, is_write, num_bytes, addr, wdata, sign_ext,
      input  rdata, busy, done, err
   );

   modport slave (
      input  start, is_write, num_bytes, addr, wdata, sign_ext,
      output rdata, busy, done, err
   );
endinterface

// File: rtl/spi_mem_ctrl_rw_bit_engine.sv
// SPI mode-0 bit engine: shifts out a preloaded MSB-aligned frame of nbits_i
// bits, CLK_DIV clk cycles per sclk phase.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : start a frame (frame_i, nbits_i captured)
//   left_o       : bits remaining, counting the bit currently on the wire
//   rise_o       : this edge raises sclk (miso sample point)
//   fall_o       : this edge ends a high phase (next bit, or frame end)
//   sclk_o, mosi_o, cs_n_o : SPI pins
module spi_mem_ctrl_rw_bit_engine
   import spi_mem_ctrl_rw_pkg::*;
#(
   parameter int FW      = 64,
   parameter int CLK_DIV = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [FW-1:0]    frame_i,
   input  logic [CNT_W-1:0] nbits_i,
   output logic [CNT_W-1:0] left_o,
   output logic             rise_o,
   output logic             fall_o,
   output logic             sclk_o,
   output logic             mosi_o,
   output logic             cs_n_o
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0] div_q, div_d;
   logic             ph_q, ph_d;     // 0 = low phase, 1 = high phase
   logic             act_q, act_d;   // frame in progress, drives cs_n
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [FW-1:0]    sh_q, sh_d;
   logic             tick;

   assign tick   = act_q && (div_q == DIV_W'(CLK_DIV - 1));
   assign rise_o = tick & ~ph_q;
   assign fall_o = tick & ph_q;
   assign left_o = cnt_q;
   assign sclk_o = act_q & ph_q;
   assign mosi_o = act_q & sh_q[FW-1];
   assign cs_n_o = ~act_q;

   always_comb begin
      div_d = div_q;
      ph_d  = ph_q;
      act_d = act_q;
      cnt_d = cnt_q;
      sh_d  = sh_q;
      if (load_i) begin
         act_d = 1'b1;
         ph_d  = 1'b0;
         div_d = '0;
         cnt_d = nbits_i;
         sh_d  = frame_i;
      end else if (act_q) begin
         if (tick) begin
            div_d = '0;
            ph_d  = ~ph_q;
            // mosi only moves on the falling edge that opens the next bit
            if (ph_q) begin
               cnt_d = cnt_q - CNT_W'(1);
               sh_d  = sh_q << 1;
               if (cnt_q == CNT_W'(1)) act_d = 1'b0;
            end
         end else begin
            div_d = div_q + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q <= '0;
         ph_q  <= 1'b0;
         act_q <= 1'b0;
         cnt_q <= '0;
         sh_q  <= '0;
      end else begin
         div_q <= div_d;
         ph_q  <= ph_d;
         act_q <= act_d;
         cnt_q <= cnt_d;
         sh_q  <= sh_d;
      end
   end
endmodule

// File: rtl/spi_mem_ctrl_rw.sv
// SPI serial-SRAM controller (READ 0x03 / WRITE 0x02), 1..MAX_BYTES bytes,
// little-endian, optional sign extension of read data.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : request/response bundle (slave side)
//   sclk_o, mosi_o, cs_n_o, miso_i : SPI pins (mode 0)
module spi_mem_ctrl_rw
   import spi_mem_ctrl_rw_pkg::*;
#(
   parameter int ADDR_W    = 24,
   parameter int MAX_BYTES = 4,
   parameter int CLK_DIV   = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   spi_mem_ctrl_rw_if.slave  bus,
   output logic              sclk_o,
   output logic              mosi_o,
   output logic              cs_n_o,
   input  logic              miso_i
);
   localparam int DW = 8 * MAX_BYTES;
   localparam int FW = 8 + ADDR_W + DW;

   state_e           state_q, state_d;
   logic             wr_q, sx_q;
   logic [NB_W-1:0]  nb_q;
   logic [DW-1:0]    rx_q;
   logic [31:0]      rdata_q, rdata_d, rd_asm;
   logic             done_q, err_q;
   logic             req_ok, accept, reject;
   logic [DW-1:0]    wser;
   logic [FW-1:0]    frame;
   logic [CNT_W-1:0] nbits, data_bits, left;
   logic             rise, fall;

   assign req_ok    = (bus.num_bytes != '0) && (bus.num_bytes <= NB_W'(MAX_BYTES));
   assign accept    = (state_q == S_IDLE) && bus.start && req_ok;
   assign reject    = (state_q == S_IDLE) && bus.start && !req_ok;
   assign nbits     = CNT_W'(8 + ADDR_W) + (CNT_W'(bus.num_bytes) << 3);
   assign data_bits = CNT_W'(nb_q) << 3;

   // Byte 0 leads on the wire, so it goes to the top of the shift frame.
   always_comb begin
      wser = '0;
      for (int k = 0; k < MAX_BYTES; k++) wser[DW-1-8*k -: 8] = bus.wdata[8*k +: 8];
      frame = {(bus.is_write ? SPI_CMD_WRITE : SPI_CMD_READ), bus.addr, wser};
   end

   spi_mem_ctrl_rw_bit_engine #(.FW(FW), .CLK_DIV(CLK_DIV)) u_eng (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (accept),
      .frame_i (frame),
      .nbits_i (nbits),
      .left_o  (left),
      .rise_o  (rise),
      .fall_o  (fall),
      .sclk_o  (sclk_o),
      .mosi_o  (mosi_o),
      .cs_n_o  (cs_n_o)
   );

   // Phase boundaries fall out of the engine's remaining-bit count.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = S_CMD;
         S_CMD:  if (fall && left == CNT_W'(ADDR_W) + data_bits + CNT_W'(1)) state_d = S_ADDR;
         S_ADDR: if (fall && left == data_bits + CNT_W'(1)) state_d = S_DATA;
         S_DATA: if (fall && left == CNT_W'(1)) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // rx_q holds the first received byte highest; flip into little-endian rdata.
   always_comb begin
      rd_asm = '0;
      for (int k = 0; k < 4; k++) begin
         if (k < int'(nb_q)) rd_asm[8*k +: 8] = rx_q[8*(int'(nb_q)-1-k) +: 8];
         else                rd_asm[8*k +: 8] = {8{sx_q & rx_q[7]}};
      end
      rdata_d = rdata_q;
      if (state_q == S_DATA && state_d == S_DONE && !wr_q) rdata_d = rd_asm;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         wr_q    <= 1'b0;
         sx_q    <= 1'b0;
         nb_q    <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         done_q  <= (state_q == S_DATA && state_d == S_DONE) | reject;
         err_q   <= reject;
         if (accept) begin
            wr_q <= bus.is_write;
            sx_q <= bus.sign_ext;
            nb_q <= bus.num_bytes;
            rx_q <= '0;
         end else if (rise && state_q == S_DATA) begin
            rx_q <= {rx_q[DW-2:0], miso_i};
         end
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.busy  = (state_q != S_IDLE);
   assign bus.done  = done_q;
   assign bus.err   = err_q;
endmodule

// File: doc/spi_mem_ctrl_rw.md
Name: spi_mem_ctrl_rw

Overview:
Parametrised SPI memory controller serving both instruction fetch and data load/store for the rv32e core. It handles the 23LC1024-style serial SRAM protocol: READ 0x03, WRITE 0x02, address MSB-first, then data. Reads and writes are 1 to MAX_BYTES bytes, little-endian, with optional sign extension of the read result. It sits between the core sequencer and the uo_out/ui_in pins, and adds write support, a configurable SCLK divider and error reporting.

Parameters:
ADDR_W, 24, address bits sent on the bus; must be a multiple of 8, range 8..32
MAX_BYTES, 4, maximum bytes per transaction; range 1..4
CLK_DIV, 1, clk cycles per SCLK phase (low or high); must be at least 1

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
start  in  1  request strobe; sampled only in IDLE
is_write  in  1  1=WRITE (0x02), 0=READ (0x03)
num_bytes  in  3  transfer length in bytes
addr  in  ADDR_W  byte address of the first byte
wdata  in  8*MAX_BYTES  write data; byte k at addr+k is wdata[8k+7:8k]
sign_ext  in  1  read only: sign-extend from the top received byte
rdata  out  32  read result; held until the next completed read
busy  out  1  high from the cycle after start is accepted through the done cycle
done  out  1  one-cycle completion pulse
err  out  1  high together with done when the request was rejected
sclk  out  1  SPI clock, mode 0, idle low
mosi  out  1  SPI data out
cs_n  out  1  chip select, active low
miso  in  1  SPI data in

Behaviour:
- Reset values: rdata=0, busy=0, done=0, err=0, sclk=0, mosi=0, cs_n=1, state=IDLE. Reset wins over every other input.
- Reset mid-transaction: at the next edge cs_n=1 and sclk=0. No done pulse is produced, and the partial rdata is discarded (rdata=0).
- The request inputs (is_write, num_bytes, addr, wdata, sign_ext) are latched on the start cycle. Later changes to them are ignored. start while busy is ignored.
- Rejected request: num_bytes==0 or num_bytes>MAX_BYTES. done=1 and err=1 on the next cycle. No bus activity, busy stays 0, rdata is unchanged.
- States and transitions:
  - IDLE -> CMD on a valid start.
  - CMD: 8 bits.
  - ADDR: ADDR_W bits.
  - DATA: 8*num_bytes bits.
  - DONE: then return to IDLE.
- Bit timing:
  - Entering CMD: cs_n=0, sclk=0, mosi=cmd[7].
  - Each bit is CLK_DIV cycles with sclk low, then CLK_DIV cycles with sclk high.
  - mosi changes only on the edge that returns sclk low, which starts the next bit.
  - miso is sampled on the edge that raises sclk.
  - Bits are MSB-first within the command, the address and each data byte.
- Data byte order:
  - Write: wdata byte 0 is sent first.
  - Read: the first received byte goes to rdata[7:0], byte k to rdata[8k+7:8k].
  - Unused upper read bytes are 0, or copies of the top received byte's bit 7 when sign_ext=1.
  - Write transactions leave rdata unchanged.
- End of transaction: the edge that ends the final high phase enters DONE. In that cycle sclk=0, cs_n=1, done=1 and busy=1, and rdata is valid at the same time as done. The next cycle is IDLE with busy=0.
- Latency: if start is sampled at edge T, done is high in cycle T + 1 + (8+ADDR_W+8*N)*2*CLK_DIV.
  - Example: ADDR_W=24, N=4, CLK_DIV=1 gives T+129.
  - A new start may be accepted in the first IDLE cycle after done.
- Minimum cs_n high time between transactions is 2 clk cycles: the DONE cycle plus the IDLE cycle.

Decomposition:
- Shared package rv_mem_pkg:
  - localparams SPI_CMD_READ=8'h03 and SPI_CMD_WRITE=8'h02
  - the state encoding: IDLE, CMD, ADDR, DATA, DONE
  - the byte-count width
- One natural sub-module, spi_bit_engine. It owns the divider counter, sclk generation, a shift register up to 8+32+32 bits, the bit counter and the sample strobe.
- The top spi_mem_ctrl_rw does request latching, rejection, byte reordering and sign extension.

Test Plan:
- READ, CLK_DIV=1, addr=0x000010, N=4, slave returns 0x13,0x05,0x00,0x00.
  - mosi carries 0x03 then 0x000010.
  - rdata=0x00000513.
  - done in cycle T+129, 64 sclk rising edges.
- READ, N=1, sign_ext=1, byte 0x80 -> rdata=0xFFFFFF80. Repeat with sign_ext=0 -> rdata=0x00000080.
- WRITE, N=2, addr=0x0000FF, wdata=0xBEEF.
  - mosi carries 0x02, 0x0000FF, 0xEF, 0xBE.
  - rdata is unchanged and err=0.
- CLK_DIV=3, N=2 read.
  - sclk high and low phases are each 3 cycles.
  - done in cycle T+1+48*6=T+289.
  - miso is sampled only on rising edges: toggle miso mid-high-phase and check rdata is unaffected.
- num_bytes=0, then num_bytes=5: each gives done=1 and err=1 one cycle later, cs_n stays 1 and busy stays 0.
- Assert rst during the ADDR phase: cs_n=1 and sclk=0 next cycle, no done. A following READ completes correctly. A start pulsed during busy is ignored, so the transaction count is unchanged.
